rgen_axi4lite_host_if: RTL and testbench

AXI4-Lite slave front end of the generated register block. Accepts AXI4-Lite write (AW+W) and read (AR) transactions, serialises them into single internal register commands, and drives the command side of the response mux. It captures the mux's registered response (ready, read data, 3-bit status) and returns it on the B or R channel with the status mapped to an AXI response code. One transaction is outstanding at a time.

---
 rtl/rgen_axi4lite_host_if_if.sv | 49 ++++
 rtl/rgen_axi4lite_host_if.sv | 130 +++++++++++++
 tb/tb_rgen_axi4lite_host_if.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgen_axi4lite_host_if_if.sv
// Bus bundle for the AXI4-Lite register front end: AXI4-Lite channels plus the
// command/response side toward the register response mux.
interface rgen_axi4lite_host_if_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
);
    logic                      awvalid;
    logic                      awready;
    logic [ADDRESS_WIDTH-1:0]  awaddr;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDRESS_WIDTH-1:0]  araddr;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;
    logic                      command_valid;
    logic                      write;
    logic [ADDRESS_WIDTH-1:0]  address;
    logic [DATA_WIDTH-1:0]     write_data;
    logic [DATA_WIDTH-1:0]     write_mask;
    logic                      response_ready;
    logic [DATA_WIDTH-1:0]     read_data;
    logic [2:0]                status;

    // The slave side is the register block front end; master is the bus host plus mux.
    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, rready,
        input  response_ready, read_data, status,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
        output command_valid, write, address, write_data, write_mask
    );

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, rready,
        output response_ready, read_data, status,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
        input  command_valid, write, address, write_data, write_mask
    );
endinterface

// File: rtl/rgen_axi4lite_host_if.sv
// AXI4-Lite slave front end: serialises AW+W / AR into single register commands
// and returns the mux response on B or R, one transaction at a time.
module rgen_axi4lite_host_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    rgen_axi4lite_host_if_if.slave  bus
);
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] WRITE_CMD  = 3'd1;
    localparam logic [2:0] READ_CMD   = 3'd2;
    localparam logic [2:0] WRITE_RESP = 3'd3;
    localparam logic [2:0] READ_RESP  = 3'd4;

    logic [2:0]               state;
    logic                     rr_write;
    logic                     write_req;
    logic                     read_req;
    logic                     contended;
    logic                     grant_write;
    logic                     grant_read;
    logic [DATA_WIDTH-1:0]    strb_mask;
    logic [1:0]               mapped_resp;
    logic                     write_q;
    logic [ADDRESS_WIDTH-1:0] address_q;
    logic [DATA_WIDTH-1:0]    write_data_q;
    logic [DATA_WIDTH-1:0]    write_mask_q;
    logic [1:0]               bresp_q;
    logic [1:0]               rresp_q;
    logic [DATA_WIDTH-1:0]    rdata_q;

    // A write needs both AW and W present; rr_write picks the winner only under contention.
    always_comb begin
        write_req   = bus.awvalid && bus.wvalid;
        read_req    = bus.arvalid;
        contended   = write_req && read_req;
        grant_write = rst_n && (state == IDLE) && write_req && (!read_req || rr_write);
        grant_read  = rst_n && (state == IDLE) && read_req && (!write_req || !rr_write);
    end

    always_comb begin
        strb_mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            strb_mask[i] = bus.wstrb[i/8];
        end
    end

    // Mux status is {exokay, decode_error, slave_error}; decode error dominates.
    always_comb begin
        if (bus.status[1]) begin
            mapped_resp = 2'b11;
        end else if (bus.status[0]) begin
            mapped_resp = 2'b10;
        end else if (bus.status[2]) begin
            mapped_resp = 2'b01;
        end else begin
            mapped_resp = 2'b00;
        end
    end

    assign bus.awready       = grant_write;
    assign bus.wready        = grant_write;
    assign bus.arready       = grant_read;
    assign bus.command_valid = (state == WRITE_CMD) || (state == READ_CMD);
    assign bus.bvalid        = (state == WRITE_RESP);
    assign bus.rvalid        = (state == READ_RESP);
    assign bus.write         = write_q;
    assign bus.address       = address_q;
    assign bus.write_data    = write_data_q;
    assign bus.write_mask    = write_mask_q;
    assign bus.bresp         = bresp_q;
    assign bus.rresp         = rresp_q;
    assign bus.rdata         = rdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_write     <= 1'b1;
            write_q      <= 1'b0;
            address_q    <= '0;
            write_data_q <= '0;
            write_mask_q <= '0;
            bresp_q      <= 2'b00;
            rresp_q      <= 2'b00;
            rdata_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_write) begin
                        state        <= WRITE_CMD;
                        write_q      <= 1'b1;
                        address_q    <= bus.awaddr;
                        write_data_q <= bus.wdata;
                        write_mask_q <= strb_mask;
                        if (contended) rr_write <= 1'b0;
                    end else if (grant_read) begin
                        state        <= READ_CMD;
                        write_q      <= 1'b0;
                        address_q    <= bus.araddr;
                        write_data_q <= '0;
                        write_mask_q <= '0;
                        if (contended) rr_write <= 1'b1;
                    end
                end
                WRITE_CMD: begin
                    if (bus.response_ready) begin
                        bresp_q <= mapped_resp;
                        state   <= WRITE_RESP;
                    end
                end
                READ_CMD: begin
                    if (bus.response_ready) begin
                        rdata_q <= bus.read_data;
                        rresp_q <= mapped_resp;
                        state   <= READ_RESP;
                    end
                end
                WRITE_RESP: begin
                    if (bus.bready) state <= IDLE;
                end
                READ_RESP: begin
                    if (bus.rready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rgen_axi4lite_host_if.sv
// Randomised self-checking bench for rgen_axi4lite_host_if with a cycle-level
// mux responder and a transaction-level expectation model.
module tb_rgen_axi4lite_host_if;
    localparam int AW = 16;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rgen_axi4lite_host_if_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    rgen_axi4lite_host_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mux_data;
    logic [2:0]    mux_status;
    logic          cv_prev = 1'b0;

    logic [DW-1:0] last_rdata;
    logic [1:0]    last_rresp;
    logic [1:0]    last_bresp;
    logic          rr_model;

    // Mux model: ready one cycle after command valid, garbage data/status otherwise.
    always @(negedge clk) begin
        bus.response_ready = bus.command_valid && cv_prev;
        cv_prev            = bus.command_valid && !bus.response_ready;
        bus.read_data      = bus.response_ready ? mux_data : ~mux_data;
        bus.status         = bus.response_ready ? mux_status : ~mux_status;
    end

    function automatic logic [1:0] exp_resp(input logic [2:0] s);
        if (s[1]) return 2'b11;
        if (s[0]) return 2'b10;
        if (s[2]) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [DW-1:0] exp_mask(input logic [DW/8-1:0] strb);
        logic [DW-1:0] m;
        m = '0;
        for (int b = 0; b < DW/8; b++) begin
            if (strb[b]) m = m | ({{(DW-8){1'b0}}, 8'hFF} << (8*b));
        end
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        tick();
        tick();
        total++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin
            bad++; $display("[TB] FAIL reset_ready: got %b want 000", {bus.awready, bus.wready, bus.arready});
        end
        total++;
        if ({bus.command_valid, bus.bvalid, bus.rvalid, bus.write} !== 4'b0000) begin
            bad++; $display("[TB] FAIL reset_valid: got %b want 0000", {bus.command_valid, bus.bvalid, bus.rvalid, bus.write});
        end
        total++;
        if ({bus.bresp, bus.rresp} !== 4'b0000 || bus.rdata !== '0) begin
            bad++; $display("[TB] FAIL reset_resp: got %b/%b/%h want 00/00/0", bus.bresp, bus.rresp, bus.rdata);
        end
        total++;
        if (bus.address !== '0 || bus.write_data !== '0 || bus.write_mask !== '0) begin
            bad++; $display("[TB] FAIL reset_cmd: got %h/%h/%h want 0", bus.address, bus.write_data, bus.write_mask);
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        rst_n = 1'b1;
        last_rdata = '0; last_rresp = 2'b00; last_bresp = 2'b00; rr_model = 1'b1;
        tick();
    endtask

    task automatic test_write_basic();
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        bus.awaddr = 16'h0010; bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'b0011;
        mux_status = 3'b000; mux_data = $urandom;
        #1;
        total++;
        if (bus.awready !== 1'b1 || bus.wready !== 1'b1) begin
            bad++; $display("[TB] FAIL wr_grant: got %b%b want 11", bus.awready, bus.wready);
        end
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        total++;
        if (bus.command_valid !== 1'b1 || bus.write !== 1'b1) begin
            bad++; $display("[TB] FAIL wr_cmd_c1: got cv=%b wr=%b want 1 1", bus.command_valid, bus.write);
        end
        total++;
        if (bus.address !== 16'h0010 || bus.write_data !== 32'hDEADBEEF) begin
            bad++; $display("[TB] FAIL wr_cmd_fields: got %h/%h want 0010/deadbeef", bus.address, bus.write_data);
        end
        total++;
        if (bus.write_mask !== 32'h0000FFFF) begin
            bad++; $display("[TB] FAIL wr_mask: got %h want 0000ffff", bus.write_mask);
        end
        tick();
        total++;
        if (bus.command_valid !== 1'b1 || bus.bvalid !== 1'b0) begin
            bad++; $display("[TB] FAIL wr_c2: got cv=%b bv=%b want 1 0", bus.command_valid, bus.bvalid);
        end
        tick();
        total++;
        if (bus.bvalid !== 1'b1 || bus.command_valid !== 1'b0 || bus.bresp !== 2'b00) begin
            bad++; $display("[TB] FAIL wr_c3: got bv=%b cv=%b bresp=%b want 1 0 00", bus.bvalid, bus.command_valid, bus.bresp);
        end
        tick();
        total++;
        if (bus.bvalid !== 1'b0) begin
            bad++; $display("[TB] FAIL wr_c4: got bv=%b want 0", bus.bvalid);
        end
        last_bresp = 2'b00;
    endtask

    task automatic test_read_status();
        logic [AW-1:0] t_addr [5] = '{16'h0004, 16'h0FFC, 16'h0FFC, 16'h0100, 16'h0200};
        logic [2:0]    t_st   [5] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b111};
        logic [1:0]    t_resp [5] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b11};
        for (int i = 0; i < 5; i++) begin
            bus.arvalid = 1'b1; bus.araddr = t_addr[i];
            mux_data = (i == 0) ? 32'h12345678 : $urandom;
            mux_status = t_st[i];
            #1;
            total++;
            if (bus.arready !== 1'b1 || bus.awready !== 1'b0) begin
                bad++; $display("[TB] FAIL rd_grant[%0d]: got ar=%b aw=%b want 1 0", i, bus.arready, bus.awready);
            end
            tick();
            bus.arvalid = 1'b0;
            total++;
            if (bus.command_valid !== 1'b1 || bus.write !== 1'b0 || bus.address !== t_addr[i]
                || bus.write_data !== '0 || bus.write_mask !== '0) begin
                bad++; $display("[TB] FAIL rd_cmd[%0d]: got cv=%b wr=%b a=%h d=%h m=%h want 1 0 %h 0 0", i,
                    bus.command_valid, bus.write, bus.address, bus.write_data, bus.write_mask, t_addr[i]);
            end
            tick();
            tick();
            total++;
            if (bus.rvalid !== 1'b1 || bus.command_valid !== 1'b0 || bus.rdata !== mux_data || bus.rresp !== t_resp[i]) begin
                bad++; $display("[TB] FAIL rd_resp[%0d]: got rv=%b cv=%b d=%h r=%b want 1 0 %h %b", i,
                    bus.rvalid, bus.command_valid, bus.rdata, bus.rresp, mux_data, t_resp[i]);
            end
            tick();
            total++;
            if (bus.rvalid !== 1'b0 || bus.rdata !== mux_data || bus.rresp !== t_resp[i]) begin
                bad++; $display("[TB] FAIL rd_hold[%0d]: got rv=%b d=%h r=%b want 0 %h %b", i,
                    bus.rvalid, bus.rdata, bus.rresp, mux_data, t_resp[i]);
            end
            last_rdata = mux_data; last_rresp = t_resp[i];
        end
    endtask

    task automatic test_contention();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rr_model = 1'b1;
        last_rdata = '0; last_rresp = 2'b00; last_bresp = 2'b00;
        mux_status = 3'b000; mux_data = $urandom;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        bus.awaddr = 16'h0020; bus.wdata = $urandom; bus.wstrb = 4'hF; bus.araddr = 16'h0024;
        for (int g = 0; g < 4; g++) begin
            #1;
            total++;
            if (bus.awready !== rr_model || bus.arready !== !rr_model) begin
                bad++; $display("[TB] FAIL contend_grant[%0d]: got aw=%b ar=%b want %b %b", g,
                    bus.awready, bus.arready, rr_model, !rr_model);
            end
            tick();
            tick();
            tick();
            total++;
            if (bus.bvalid !== rr_model || bus.rvalid !== !rr_model) begin
                bad++; $display("[TB] FAIL contend_resp[%0d]: got bv=%b rv=%b want %b %b", g,
                    bus.bvalid, bus.rvalid, rr_model, !rr_model);
            end
            if (!rr_model) begin
                last_rdata = mux_data; last_rresp = 2'b00;
            end else begin
                last_bresp = 2'b00;
            end
            rr_model = !rr_model;
            tick();
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        tick();
    endtask

    task automatic test_bready_stall();
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.awaddr = 16'h0040; bus.wdata = $urandom; bus.wstrb = 4'b1000;
        mux_status = 3'b001;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.arvalid = 1'b1; bus.araddr = 16'h0044;
        tick();
        bus.bready = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            total++;
            if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b10 || bus.arready !== 1'b0) begin
                bad++; $display("[TB] FAIL stall[%0d]: got bv=%b bresp=%b ar=%b want 1 10 0", c,
                    bus.bvalid, bus.bresp, bus.arready);
            end
            if (c == 4) bus.bready = 1'b1;
            tick();
        end
        last_bresp = 2'b10;
        mux_status = 3'b000; mux_data = $urandom;
        total++;
        if (bus.bvalid !== 1'b0 || bus.arready !== 1'b1) begin
            bad++; $display("[TB] FAIL stall_release: got bv=%b ar=%b want 0 1", bus.bvalid, bus.arready);
        end
        tick();
        bus.arvalid = 1'b0;
        tick();
        tick();
        total++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== mux_data) begin
            bad++; $display("[TB] FAIL stall_read: got rv=%b d=%h want 1 %h", bus.rvalid, bus.rdata, mux_data);
        end
        last_rdata = mux_data; last_rresp = 2'b00;
        tick();
    endtask

    task automatic test_aw_only();
        bus.awvalid = 1'b1; bus.wvalid = 1'b0; bus.awaddr = 16'h0050;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (bus.awready !== 1'b0 || bus.wready !== 1'b0 || bus.command_valid !== 1'b0) begin
                bad++; $display("[TB] FAIL aw_only[%0d]: got aw=%b w=%b cv=%b want 0 0 0", c,
                    bus.awready, bus.wready, bus.command_valid);
            end
            tick();
        end
        bus.awvalid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bus.arvalid = 1'b1; bus.araddr = 16'h0060; mux_status = 3'b000; mux_data = $urandom;
        tick();
        bus.arvalid = 1'b0;
        total++;
        if (bus.command_valid !== 1'b1) begin
            bad++; $display("[TB] FAIL rstmid_cmd: got cv=%b want 1", bus.command_valid);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++;
        if (bus.command_valid !== 1'b0 || bus.rvalid !== 1'b0 || bus.address !== '0 || bus.rdata !== '0) begin
            bad++; $display("[TB] FAIL rstmid_outs: got cv=%b rv=%b a=%h d=%h want 0 0 0 0",
                bus.command_valid, bus.rvalid, bus.address, bus.rdata);
        end
        rr_model = 1'b1; last_rdata = '0; last_rresp = 2'b00; last_bresp = 2'b00;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (bus.rvalid !== 1'b0) begin
                bad++; $display("[TB] FAIL rstmid_norv[%0d]: got rv=%b want 0", c, bus.rvalid);
            end
        end
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.awaddr = 16'h0064; bus.wdata = $urandom; bus.wstrb = 4'hF;
        #1;
        total++;
        if (bus.awready !== 1'b1) begin
            bad++; $display("[TB] FAIL rstmid_idle: got aw=%b want 1", bus.awready);
        end
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_random();
        logic          is_write;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [3:0]    s;
        for (int n = 0; n < 40; n++) begin
            is_write = 1'($urandom_range(0, 1));
            a = 16'($urandom); d = $urandom; s = 4'($urandom);
            mux_status = 3'($urandom); mux_data = $urandom;
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
            if (is_write) begin
                bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
            end else begin
                bus.arvalid = 1'b1; bus.araddr = a;
            end
            tick();
            bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
            total++;
            if (bus.command_valid !== 1'b1 || bus.write !== is_write || bus.address !== a
                || bus.write_data !== (is_write ? d : '0) || bus.write_mask !== (is_write ? exp_mask(s) : '0)) begin
                bad++; $display("[TB] FAIL rand_cmd[%0d]: got cv=%b wr=%b a=%h d=%h m=%h want 1 %b %h %h %h", n,
                    bus.command_valid, bus.write, bus.address, bus.write_data, bus.write_mask,
                    is_write, a, is_write ? d : '0, is_write ? exp_mask(s) : '0);
            end
            tick();
            tick();
            if (is_write) begin
                last_bresp = exp_resp(mux_status);
            end else begin
                last_rdata = mux_data; last_rresp = exp_resp(mux_status);
            end
            total++;
            if (bus.bvalid !== is_write || bus.rvalid !== !is_write || bus.bresp !== last_bresp
                || bus.rresp !== last_rresp || bus.rdata !== last_rdata) begin
                bad++; $display("[TB] FAIL rand_resp[%0d]: got bv=%b rv=%b b=%b r=%b d=%h want %b %b %b %b %h", n,
                    bus.bvalid, bus.rvalid, bus.bresp, bus.rresp, bus.rdata,
                    is_write, !is_write, last_bresp, last_rresp, last_rdata);
            end
            tick();
        end
    endtask

    initial begin
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        bus.awaddr = '0; bus.araddr = '0; bus.wdata = '0; bus.wstrb = '0;
        bus.bready = 1'b1; bus.rready = 1'b1;
        mux_data = '0; mux_status = 3'b000;
        rst_n = 1'b0;
        test_reset();
        test_write_basic();
        test_read_status();
        test_contention();
        test_bready_stall();
        test_aw_only();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
